// File: rtl/mod_cfg_pkg.sv
// Shared constants and types for the configuration frame sequencer.
// Defaults mirror the DDS generator: one frame per DDS, one word per register.
package mod_cfg_pkg;

  localparam int NREG = 11;
  localparam int NDDS = 16;

  localparam int CFG_WORD_AW  = $clog2(NREG * NDDS);
  localparam int CFG_FRAME_AW = $clog2(NDDS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/mod_cfg_sequencer_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// Read-first: a same-address read and write in one cycle returns the old word.
module cfg_ram #(
  parameter int DEPTH = 176,
  parameter int AW    = 8,
  parameter int B     = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [B-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [B-1:0]  rd_data
);

  logic [B-1:0] mem [DEPTH];

  // No reset on purpose: contents survive a control reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mod_cfg_sequencer.sv
// Streams a run of parameter frames from the frame memory onto an AXI-Stream
// port, one word per cycle at full rate, with a 2-entry skid buffer for stalls.
module mod_cfg_sequencer
  import mod_cfg_pkg::*;
#(
  parameter int NWORDS  = NREG,
  parameter int NFRAMES = NDDS,
  parameter int B       = 32
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                wr_en,
  input  logic [$clog2(NFRAMES*NWORDS)-1:0]   wr_addr,
  input  logic [B-1:0]                        wr_data,
  input  logic                                start,
  input  logic [$clog2(NFRAMES)-1:0]          first_frame,
  input  logic [$clog2(NFRAMES):0]            num_frames,
  input  logic                                abort,
  output logic                                busy,
  output logic                                done,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [B-1:0]                        m_axis_tdata,
  output logic                                m_axis_tlast
);

  localparam int AW = $clog2(NFRAMES * NWORDS);
  localparam int FW = $clog2(NFRAMES);
  localparam int LW = FW + 1;
  localparam int WW = $clog2(NWORDS);
  localparam logic [AW-1:0] LAST_BASE = AW'((NFRAMES - 1) * NWORDS);

  cfg_state_e    state_q, state_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] left_q, left_d;
  logic          issued_all_q, issued_all_d;
  logic          done_q, done_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic          rd_final_q, rd_final_d;
  logic [B-1:0]  sk_data_q [2];
  logic [B-1:0]  sk_data_d [2];
  logic [1:0]    sk_last_q, sk_last_d;
  logic [1:0]    sk_final_q, sk_final_d;
  logic [1:0]    sk_cnt_q, sk_cnt_d;
  logic [1:0]    sk_cnt_pop;

  logic [AW-1:0] start_base;
  logic [AW-1:0] rd_addr;
  logic [B-1:0]  rd_data;
  logic          issue, hs, pop, push, out_from_sk, head_final;

  cfg_ram #(
    .DEPTH (NFRAMES * NWORDS),
    .AW    (AW),
    .B     (B)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // first_frame*NWORDS as a constant shift-and-add; only used once per burst.
  always_comb begin
    start_base = '0;
    for (int i = 0; i < FW; i++) begin
      if (first_frame[i]) start_base = start_base + AW'(NWORDS << i);
    end
  end

  assign rd_addr = base_q + AW'(word_cnt_q);

  // The RAM output register is the newest stage; skid entries are older and go first.
  assign out_from_sk   = (sk_cnt_q != 2'd0);
  assign m_axis_tvalid = out_from_sk | rd_vld_q;
  assign m_axis_tdata  = out_from_sk ? sk_data_q[0] : (rd_vld_q ? rd_data : '0);
  assign m_axis_tlast  = out_from_sk ? sk_last_q[0] : (rd_vld_q & rd_last_q);
  assign head_final    = out_from_sk ? sk_final_q[0] : (rd_vld_q & rd_final_q);

  assign hs   = m_axis_tvalid & m_axis_tready;
  assign pop  = hs & out_from_sk;
  assign push = rd_vld_q & ~(hs & ~out_from_sk);
  // Issue only when at most one word is held, so a stalled pipeline never overflows.
  assign issue = (state_q == RUN) & ~issued_all_q & ~abort &
                 ((sk_cnt_q == 2'd0) | ((sk_cnt_q == 2'd1) & ~rd_vld_q));

  assign busy = (state_q == RUN);
  assign done = done_q;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    base_d       = base_q;
    left_d       = left_q;
    issued_all_d = issued_all_q;
    rd_last_d    = rd_last_q;
    rd_final_d   = rd_final_q;
    rd_vld_d     = issue;
    done_d       = 1'b0;
    sk_data_d    = sk_data_q;
    sk_last_d    = sk_last_q;
    sk_final_d   = sk_final_q;

    sk_cnt_pop = sk_cnt_q - 2'(pop);
    if (pop) begin
      sk_data_d[0]  = sk_data_q[1];
      sk_last_d[0]  = sk_last_q[1];
      sk_final_d[0] = sk_final_q[1];
    end
    if (push) begin
      sk_data_d[sk_cnt_pop[0]]  = rd_data;
      sk_last_d[sk_cnt_pop[0]]  = rd_last_q;
      sk_final_d[sk_cnt_pop[0]] = rd_final_q;
    end
    sk_cnt_d = sk_cnt_pop + 2'(push);

    if (issue) begin
      rd_last_d  = (word_cnt_q == WW'(NWORDS - 1));
      rd_final_d = (word_cnt_q == WW'(NWORDS - 1)) && (left_q == LW'(1));
      if (word_cnt_q == WW'(NWORDS - 1)) begin
        word_cnt_d = '0;
        base_d     = (base_q == LAST_BASE) ? '0 : base_q + AW'(NWORDS);
        left_d     = left_q - LW'(1);
        if (left_q == LW'(1)) issued_all_d = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + WW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_frames == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            word_cnt_d   = '0;
            base_d       = start_base;
            left_d       = num_frames;
            issued_all_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (hs && head_final) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      done_d       = 1'b0;
      sk_cnt_d     = 2'd0;
      rd_vld_d     = 1'b0;
      issued_all_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      base_q       <= '0;
      left_q       <= '0;
      issued_all_q <= 1'b0;
      done_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_final_q   <= 1'b0;
      sk_data_q[0] <= '0;
      sk_data_q[1] <= '0;
      sk_last_q    <= '0;
      sk_final_q   <= '0;
      sk_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      base_q       <= base_d;
      left_q       <= left_d;
      issued_all_q <= issued_all_d;
      done_q       <= done_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      rd_final_q   <= rd_final_d;
      sk_data_q    <= sk_data_d;
      sk_last_q    <= sk_last_d;
      sk_final_q   <= sk_final_d;
      sk_cnt_q     <= sk_cnt_d;
    end
  end

endmodule

// File: tb/tb_mod_cfg_sequencer.sv
// Directed bench for mod_cfg_sequencer: frame streaming, wrap, stalls, abort, reset.
module tb_mod_cfg_sequencer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [3:0]  first_frame = '0;
  logic [4:0]  num_frames = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_w[$];
  bit          got_l[$];
  int          got_c[$];
  int          done_cyc;
  int          stall_viol;

  mod_cfg_sequencer dut (
    .aclk          (aclk),
    .areset        (areset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .first_frame   (first_frame),
    .num_frames    (num_frames),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 176; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 32'(a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Asserts start for one cycle; returns in cycle t+1.
  task automatic launch(input int ff, input int nf);
    first_frame = 4'(ff); num_frames = 5'(nf); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records accepted words; cycle index 1 is the cycle the task is entered in.
  task automatic collect(input int budget, input bit rnd);
    logic [31:0] prev_d;
    logic        prev_l;
    bit          prev_stall;
    got_w.delete(); got_l.delete(); got_c.delete();
    done_cyc = -1; stall_viol = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
        stall_viol++;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        got_w.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        got_c.push_back(c);
      end
      prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
      prev_d = m_axis_tdata; prev_l = m_axis_tlast;
      tick();
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({busy, done, m_axis_tvalid, m_axis_tlast} !== 4'b0000 || m_axis_tdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy/done/tvalid/tlast=%b tdata=%h expected 0000 and 0",
               {busy, done, m_axis_tvalid, m_axis_tlast}, m_axis_tdata);
    end
    areset = 1'b0;
    tick();
    n_tests++;
    if ({busy, done, m_axis_tvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy/done/tvalid=%b expected 000", {busy, done, m_axis_tvalid});
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_frame();
    launch(0, 1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy: got %b expected 1 at t+1", busy);
    end
    collect(40, 1'b0);
    n_tests++;
    if (got_w.size() != 11) begin
      n_fail++; $display("FAIL single_count: got %0d words expected 11", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 11; i++) begin
      n_tests++;
      if (got_w[i] !== 32'(i) || got_l[i] !== (i == 10) || got_c[i] != i + 2) begin
        n_fail++;
        $display("FAIL single_word%0d: got data=%0d last=%0b cycle=t+%0d expected data=%0d last=%0b cycle=t+%0d",
                 i, got_w[i], got_l[i], got_c[i], i, (i == 10), i + 2);
      end
    end
    n_tests++;
    if (done_cyc != 13) begin
      n_fail++; $display("FAIL single_done: got done at t+%0d expected t+13", done_cyc);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_fall: got busy=%b in done cycle expected 0", busy);
    end
    $display("[TB] single frame: %0d words, done at t+%0d", got_w.size(), done_cyc);
  endtask

  // Entered in a done cycle: start here must be accepted.
  task automatic test_back_to_back();
    launch(2, 1);
    collect(40, 1'b0);
    n_tests++;
    if (got_w.size() != 11) begin
      n_fail++; $display("FAIL b2b_count: got %0d words expected 11", got_w.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_tests++;
        if (got_w[i] !== 32'(22 + i) || got_c[i] != i + 2) begin
          n_fail++;
          $display("FAIL b2b_word%0d: got data=%0d cycle=t+%0d expected data=%0d cycle=t+%0d",
                   i, got_w[i], got_c[i], 22 + i, i + 2);
        end
      end
    end
    $display("[TB] back-to-back burst: %0d words, done at t+%0d", got_w.size(), done_cyc);
  endtask

  task automatic test_wraparound();
    int nlast;
    launch(15, 2);
    collect(80, 1'b0);
    n_tests++;
    if (got_w.size() != 22) begin
      n_fail++; $display("FAIL wrap_count: got %0d words expected 22", got_w.size());
    end
    nlast = 0;
    for (int i = 0; i < got_w.size() && i < 22; i++) begin
      n_tests++;
      if (got_w[i] !== 32'(i < 11 ? 165 + i : i - 11) || got_l[i] !== (i == 10 || i == 21)) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got data=%0d last=%0b expected data=%0d last=%0b",
                 i, got_w[i], got_l[i], (i < 11 ? 165 + i : i - 11), (i == 10 || i == 21));
      end
      if (got_l[i]) nlast++;
    end
    n_tests++;
    if (nlast != 2 || done_cyc != 24) begin
      n_fail++; $display("FAIL wrap_tlast_done: got %0d tlast, done t+%0d expected 2 tlast, done t+24",
                         nlast, done_cyc);
    end
    $display("[TB] wraparound: %0d words, %0d tlast", got_w.size(), nlast);
  endtask

  task automatic test_backpressure();
    int bad;
    launch(3, 16);
    collect(3000, 1'b1);
    n_tests++;
    if (got_w.size() != 176) begin
      n_fail++; $display("FAIL bp_count: got %0d words expected 176", got_w.size());
    end
    bad = 0;
    for (int i = 0; i < got_w.size() && i < 176; i++) begin
      if (got_w[i] !== 32'((33 + i) % 176) || got_l[i] !== ((i % 11) == 10)) begin
        if (bad == 0)
          $display("FAIL bp_word%0d: got data=%0d last=%0b expected data=%0d last=%0b",
                   i, got_w[i], got_l[i], (33 + i) % 176, ((i % 11) == 10));
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_order: got %0d bad words expected 0", bad);
    end
    n_tests++;
    if (stall_viol != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol);
    end
    n_tests++;
    if (done_cyc < 0) begin
      n_fail++; $display("FAIL bp_done: got no done within budget expected done pulse");
    end
    $display("[TB] backpressure: %0d words, done at t+%0d", got_w.size(), done_cyc);
  endtask

  task automatic test_zero_and_busy_start();
    launch(0, 0);
    n_tests++;
    if ({done, m_axis_tvalid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL zero_done: got done/tvalid/busy=%b expected 100", {done, m_axis_tvalid, busy});
    end
    tick();
    n_tests++;
    if ({done, m_axis_tvalid} !== 2'b00) begin
      n_fail++; $display("FAIL zero_done_pulse: got done/tvalid=%b expected 00", {done, m_axis_tvalid});
    end
    launch(2, 1);
    first_frame = 4'd5; num_frames = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    collect(60, 1'b0);
    n_tests++;
    if (got_w.size() != 11 || done_cyc != 12) begin
      n_fail++; $display("FAIL busy_start_count: got %0d words done at %0d expected 11 words done at 12",
                         got_w.size(), done_cyc);
    end else begin
      n_tests++;
      if (got_w[0] !== 32'd22 || got_w[10] !== 32'd32) begin
        n_fail++; $display("FAIL busy_start_data: got first=%0d last=%0d expected 22 and 32", got_w[0], got_w[10]);
      end
    end
    $display("[TB] zero frames and start-while-busy checked");
  endtask

  task automatic test_abort();
    int nacc;
    int ndone;
    launch(1, 1);
    nacc = 0;
    for (int c = 0; c < 30 && nacc < 6; c++) begin
      if (m_axis_tvalid === 1'b1) nacc++;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if ({m_axis_tvalid, busy, done} !== 3'b000 || nacc != 6) begin
      n_fail++; $display("FAIL abort_stop: got tvalid/busy/done=%b after %0d words expected 000 after 6",
                         {m_axis_tvalid, busy, done}, nacc);
    end
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1 || m_axis_tvalid === 1'b1) ndone++;
      tick();
    end
    n_tests++;
    if (ndone != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d cycles with done/tvalid expected 0", ndone);
    end
    launch(1, 1);
    collect(40, 1'b0);
    n_tests++;
    if (got_w.size() != 11 || done_cyc != 13) begin
      n_fail++; $display("FAIL abort_restart_count: got %0d words done at %0d expected 11 done at 13",
                         got_w.size(), done_cyc);
    end else begin
      n_tests++;
      if (got_w[0] !== 32'd11 || got_w[10] !== 32'd21 || got_l[10] !== 1'b1) begin
        n_fail++; $display("FAIL abort_restart_data: got first=%0d last=%0d expected 11 and 21", got_w[0], got_w[10]);
      end
    end
    $display("[TB] abort after %0d words checked", nacc);
  endtask

  task automatic test_areset_midburst();
    wr_en = 1'b1; wr_addr = 8'd44; wr_data = 32'hCAFE0044;
    tick();
    wr_en = 1'b0;
    launch(4, 2);
    repeat (8) tick();
    areset = 1'b1;
    tick();
    n_tests++;
    if ({busy, done, m_axis_tvalid, m_axis_tlast} !== 4'b0000 || m_axis_tdata !== 32'h0) begin
      n_fail++; $display("FAIL areset_mid: got busy/done/tvalid/tlast=%b tdata=%h expected 0000 and 0",
                         {busy, done, m_axis_tvalid, m_axis_tlast}, m_axis_tdata);
    end
    areset = 1'b0;
    tick();
    launch(4, 2);
    collect(80, 1'b0);
    n_tests++;
    if (got_w.size() != 22 || done_cyc != 24) begin
      n_fail++; $display("FAIL areset_restart_count: got %0d words done at %0d expected 22 done at 24",
                         got_w.size(), done_cyc);
    end else begin
      for (int i = 0; i < 22; i++) begin
        n_tests++;
        if (got_w[i] !== (i == 0 ? 32'hCAFE0044 : 32'(44 + i))) begin
          n_fail++; $display("FAIL areset_word%0d: got %h expected %h",
                             i, got_w[i], (i == 0 ? 32'hCAFE0044 : 32'(44 + i)));
        end
      end
    end
    $display("[TB] areset mid-burst restart: %0d words", got_w.size());
  endtask

  initial begin
    test_reset();
    fill_mem();
    test_single_frame();
    test_back_to_back();
    tick();
    test_wraparound();
    tick();
    test_backpressure();
    tick();
    test_zero_and_busy_start();
    tick();
    test_abort();
    tick();
    test_areset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
